// File: rtl/vertex_mac_acc.sv
// Two-stage multiply/accumulate for one processing element. The design
// produces one saturating dot product per weight layer of a stream.
module vertex_mac_acc #(
  parameter int MULT_PER_PE = 4,
  parameter int FV_SIZE     = 8,
  parameter int ACC_W       = 32,
  parameter int LAYER_W     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sos,
  input  logic                           eos,
  input  logic                           change,
  input  logic                           valid_in,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] weight_in,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] fv_in,
  output logic                           result_valid,
  output logic [ACC_W-1:0]               result_data,
  output logic [LAYER_W-1:0]             result_layer,
  output logic                           result_ovf,
  output logic                           done,
  output logic                           busy,
  output logic                           protocol_err
);

  // state | meaning
  // IDLE  | waiting for sos; stray beats are dropped and flagged
  // ACC   | accepting beats of the current stream
  typedef enum logic {IDLE, ACC} state_t;

  localparam int PROD_W = 2 * FV_SIZE;
  localparam int SUM_W  = PROD_W + $clog2(MULT_PER_PE) + 1;
  // Extra headroom so a beat sum wider than the accumulator still saturates.
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t              state;
  logic [PROD_W-1:0]   prod_q [MULT_PER_PE];
  logic                s1_valid;
  logic                s1_change;
  logic                s1_eos;
  logic [ACC_W-1:0]    acc;
  logic                ovf;
  logic [LAYER_W-1:0]  layer;

  logic                accept;
  logic [EXT_W-1:0]    sum_ext;
  logic [EXT_W-1:0]    total;
  logic                sat;
  logic [ACC_W-1:0]    beat_val;

  assign accept = valid_in && ((state == ACC) || sos);
  assign busy   = (state == ACC) || s1_valid || result_valid;

  always_comb begin
    sum_ext = '0;
    for (int i = 0; i < MULT_PER_PE; i++) begin
      sum_ext = sum_ext + EXT_W'(prod_q[i]);
    end
    total    = EXT_W'(acc) + sum_ext;
    sat      = total > EXT_W'(ACC_MAX);
    beat_val = sat ? ACC_MAX : total[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s1_valid     <= 1'b0;
      s1_change    <= 1'b0;
      s1_eos       <= 1'b0;
      acc          <= '0;
      ovf          <= 1'b0;
      layer        <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_layer <= '0;
      result_ovf   <= 1'b0;
      done         <= 1'b0;
      protocol_err <= 1'b0;
      for (int i = 0; i < MULT_PER_PE; i++) prod_q[i] <= '0;
    end else begin
      protocol_err <= ((state == IDLE) && valid_in && !sos) ||
                      ((state == ACC) && sos) ||
                      (accept && eos && !change);

      s1_valid <= accept;
      if (accept) begin
        s1_change <= change;
        s1_eos    <= eos;
        for (int i = 0; i < MULT_PER_PE; i++) begin
          prod_q[i] <= PROD_W'(weight_in[i*FV_SIZE +: FV_SIZE]) *
                       PROD_W'(fv_in[i*FV_SIZE +: FV_SIZE]);
        end
      end

      result_valid <= 1'b0;
      done         <= 1'b0;
      if (s1_valid) begin
        if (s1_change || s1_eos) begin
          result_valid <= 1'b1;
          result_data  <= beat_val;
          result_layer <= layer;
          result_ovf   <= ovf | sat;
          done         <= s1_eos;
          acc          <= '0;
          ovf          <= 1'b0;
          layer        <= layer + LAYER_W'(1);
        end else begin
          acc <= beat_val;
          ovf <= ovf | sat;
        end
      end

      case (state)
        IDLE: begin
          if (sos) begin
            // Stage 1 can only hold a draining eos beat here, so clearing is safe.
            state <= (valid_in && eos) ? IDLE : ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            layer <= '0;
          end
        end
        ACC: begin
          if (accept && eos) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_mac_acc.sv
// Scoreboard bench: two instances (32-bit and 16-bit accumulators) share stimulus;
// directed beats push expected results, per-instance monitors pop and compare.
module tb_vertex_mac_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        sos, eos, change, valid_in;
  logic [31:0] weight_in, fv_in;

  logic        rv32, ro32, dn32, by32, pe32;
  logic [31:0] rd32;
  logic [1:0]  rl32;
  logic        rv16, ro16, dn16, by16, pe16;
  logic [15:0] rd16;
  logic [1:0]  rl16;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  layer;
    logic        ovf;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   err32 = 0;
  int   err16 = 0;

  vertex_mac_acc #(.MULT_PER_PE(4), .FV_SIZE(8), .ACC_W(32), .LAYER_W(2)) dut32 (
    .clk(clk), .reset(reset), .sos(sos), .eos(eos), .change(change), .valid_in(valid_in),
    .weight_in(weight_in), .fv_in(fv_in), .result_valid(rv32), .result_data(rd32),
    .result_layer(rl32), .result_ovf(ro32), .done(dn32), .busy(by32), .protocol_err(pe32));

  vertex_mac_acc #(.MULT_PER_PE(4), .FV_SIZE(8), .ACC_W(16), .LAYER_W(2)) dut16 (
    .clk(clk), .reset(reset), .sos(sos), .eos(eos), .change(change), .valid_in(valid_in),
    .weight_in(weight_in), .fv_in(fv_in), .result_valid(rv16), .result_data(rd16),
    .result_layer(rl16), .result_ovf(ro16), .done(dn16), .busy(by16), .protocol_err(pe16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_res(input string tag, input exp_t e, input logic [31:0] d,
                           input logic [1:0] l, input logic o, input logic dn);
    chk({tag, " data"}, d, e.data);
    chk({tag, " layer"}, {30'd0, l}, {30'd0, e.layer});
    chk({tag, " ovf"}, {31'd0, o}, {31'd0, e.ovf});
    chk({tag, " done"}, {31'd0, dn}, {31'd0, e.done});
    chk({tag, " latency"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv32 === 1'b1) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL d32 unexpected result: got data %0d, expected none", rd32);
      end else begin
        e = q32.pop_front();
        check_res("d32", e, rd32, rl32, ro32, dn32);
      end
    end else if (dn32 === 1'b1) begin
      tests++; fails++;
      $display("FAIL d32 stray done: got 1, expected 0");
    end
    if (pe32 === 1'b1) err32++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rv16 === 1'b1) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL d16 unexpected result: got data %0d, expected none", rd16);
      end else begin
        e = q16.pop_front();
        check_res("d16", e, {16'd0, rd16}, rl16, ro16, dn16);
      end
    end else if (dn16 === 1'b1) begin
      tests++; fails++;
      $display("FAIL d16 stray done: got 1, expected 0");
    end
    if (pe16 === 1'b1) err16++;
  end

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = 8'(a); lb = 8'(b); lc = 8'(c); ld = 8'(d);
    return {ld, lc, lb, la};
  endfunction

  task automatic beat(input logic s, input logic c, input logic e, input logic v,
                      input logic [31:0] w, input logic [31:0] f);
    @(negedge clk);
    sos = s; change = c; eos = e; valid_in = v; weight_in = w; fv_in = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Called in the same negedge slot as the change beat, so cyc+2 is the result cycle.
  task automatic push(input logic [31:0] d32, input logic [31:0] d16, input logic o32,
                      input logic o16, input logic [1:0] l, input logic dn);
    exp_t e;
    e.layer = l; e.done = dn; e.cyc = cyc + 2;
    e.data = d32; e.ovf = o32; q32.push_back(e);
    e.data = d16; e.ovf = o16; q16.push_back(e);
  endtask

  task automatic chk_err(input string name, input int base32, input int base16, input int n);
    chk({name, " d32 protocol_err pulses"}, err32 - base32, n);
    chk({name, " d16 protocol_err pulses"}, err16 - base16, n);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " result_valid"}, {30'd0, rv32, rv16}, 32'd0);
    chk({name, " result_data"}, rd32 | {16'd0, rd16}, 32'd0);
    chk({name, " done"}, {30'd0, dn32, dn16}, 32'd0);
    chk({name, " busy"}, {30'd0, by32, by16}, 32'd0);
    chk({name, " protocol_err"}, {30'd0, pe32, pe16}, 32'd0);
    chk({name, " layer/ovf"}, {26'd0, rl32, rl16, ro32, ro16}, 32'd0);
  endtask

  logic [31:0] ones, f255;
  int b32, b16;

  initial begin
    reset = 1'b1;
    sos = 0; eos = 0; change = 0; valid_in = 0; weight_in = 0; fv_in = 0;
    ones = pack(1, 1, 1, 1);
    f255 = pack(255, 255, 255, 255);
    idle(3);
    chk_quiet("reset");
    reset = 1'b0;
    idle(2);

    // Two beats with bubbles in between, then a final single-beat layer with eos.
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, pack(2, 2, 0, 2), ones);
    idle(2);
    beat(0, 1, 0, 1, pack(1, 0, 0, 1), pack(3, 3, 3, 3));
    push(12, 12, 0, 0, 2'd0, 0);
    beat(0, 1, 1, 1, ones, pack(5, 5, 5, 5));
    push(20, 20, 0, 0, 2'd1, 1);
    idle(4);
    chk("idle busy after stream", {30'd0, by32, by16}, 32'd0);

    // sos with first beat; back-to-back layers; busy falls the cycle after done.
    beat(1, 1, 0, 1, ones, ones);
    push(4, 4, 0, 0, 2'd0, 0);
    beat(0, 1, 1, 1, pack(2, 2, 2, 2), pack(1, 2, 3, 4));
    push(20, 20, 0, 0, 2'd1, 1);
    idle(2);
    chk("busy at done", {30'd0, by32, by16}, 32'd3);
    idle(1);
    chk("busy after done", {30'd0, by32, by16}, 32'd0);
    idle(2);

    // Saturation only in the 16-bit accumulator; sticky flag clears for the next layer.
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, f255, f255);
    beat(0, 1, 0, 1, f255, f255);
    push(520200, 65535, 0, 1, 2'd0, 0);
    beat(0, 1, 1, 1, ones, ones);
    push(4, 4, 0, 0, 2'd1, 1);
    idle(4);

    // Stray beat in IDLE, then sos inside an active stream.
    b32 = err32; b16 = err16;
    beat(0, 0, 0, 1, ones, ones);
    idle(3);
    chk_err("idle beat", b32, b16, 1);
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, ones, pack(1, 2, 3, 4));
    beat(1, 0, 0, 1, ones, ones);
    beat(0, 1, 1, 1, ones, ones);
    push(18, 18, 0, 0, 2'd0, 1);
    idle(4);
    chk_err("sos in ACC", b32, b16, 2);

    // eos without change still yields a result and a protocol error.
    b32 = err32; b16 = err16;
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 1, 1, ones, pack(2, 2, 2, 2));
    push(8, 8, 0, 0, 2'd0, 1);
    idle(4);
    chk_err("eos no change", b32, b16, 1);

    // Five back-to-back layers wrap the 2-bit layer index.
    beat(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      beat(0, 1, (k == 5), 1, pack(k, 0, 0, 0), ones);
      push(32'(k), 32'(k), 0, 0, 2'(k - 1), (k == 5));
    end
    idle(4);

    // Reset one cycle after a change beat discards its result; next stream restarts at layer 0.
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, ones, ones);
    beat(0, 1, 0, 1, ones, ones);
    @(negedge clk);
    valid_in = 0; change = 0;
    reset = 1'b1;
    idle(2);
    chk_quiet("mid-stream reset");
    reset = 1'b0;
    beat(1, 1, 1, 1, ones, pack(2, 2, 2, 2));
    push(8, 8, 0, 0, 2'd0, 1);
    idle(5);

    chk("d32 scoreboard empty", q32.size(), 0);
    chk("d16 scoreboard empty", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
